// File: rtl/flappy_pkg.sv
// Shared types and constants for the flappy collision logic.
package flappy_pkg;

    typedef enum logic [1:0] {
        ALIVE = 2'd0,
        GRACE = 2'd1,
        DEAD  = 2'd2
    } state_t;

    // Wide all-ones; users slice down to their own colour-channel width.
    localparam logic [31:0] GREEN_MAX = '1;

endpackage

// File: rtl/grace_timer.sv
// Loadable frame counter: counts down once per frame_start, done while at 1.
module grace_timer #(
    parameter int GW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          clear,
    input  logic [GW-1:0] load_val,
    input  logic          frame_start,
    output logic          done
);

    logic [GW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (frame_start && count != '0)
            count <= count - 1'b1;
    end

    assign done = (count == GW'(1));

endmodule

// File: rtl/collision_monitor.sv
// Bird/pipe/ground collision tracking with lives and post-hit invulnerability.
// state | meaning
// ALIVE | normal play, pipe or ground contact costs lives
// GRACE | invulnerable to pipes for GRACE frames after a hit
// DEAD  | out of lives, waits for restart
module collision_monitor
    import flappy_pkg::*;
#(
    parameter int XW       = 10,
    parameter int YW       = 9,
    parameter int CW       = 8,
    parameter int BIRD_X0  = 200,
    parameter int BIRD_W   = 32,
    parameter int BIRD_H   = 24,
    parameter int GROUND_Y = 440,
    parameter int LIVES    = 3,
    parameter int GRACE    = 60
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [XW-1:0] x,
    input  logic [CW-1:0] gp,
    input  logic [CW-1:0] gb,
    input  logic [YW-1:0] bird_y,
    input  logic          frame_start,
    input  logic          restart,
    output logic          hit,
    output logic          die,
    output logic [3:0]    lives,
    output logic          LEDR
);

    localparam logic [XW-1:0] X_LO     = XW'(BIRD_X0);
    localparam logic [XW-1:0] X_HI     = XW'(BIRD_X0 + BIRD_W - 1);
    localparam logic [CW-1:0] G_MAX    = GREEN_MAX[CW-1:0];
    localparam logic [YW:0]   BOX_H    = (YW+1)'(BIRD_H);
    localparam logic [YW:0]   GROUND   = (YW+1)'(GROUND_Y);
    localparam logic [3:0]    LIVES_RL = 4'(LIVES);

    state_t     state, state_n;
    logic [3:0] lives_n;
    logic       hit_n;
    logic       pipe_hit, ground_hit;
    logic       grace_load, grace_clear, grace_done;

    assign pipe_hit   = (x >= X_LO) && (x <= X_HI) && (gp == G_MAX) && (gb == G_MAX);
    // Extra bit on the sum keeps a bird near the bottom from wrapping to row 0.
    assign ground_hit = frame_start && (({1'b0, bird_y} + BOX_H) >= GROUND);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ALIVE;
            lives <= LIVES_RL;
            hit   <= 1'b0;
        end else begin
            state <= state_n;
            lives <= lives_n;
            hit   <= hit_n;
        end
    end

    always_comb begin
        state_n    = state;
        lives_n    = lives;
        hit_n      = 1'b0;
        grace_load = 1'b0;
        case (state)
            ALIVE: begin
                if (restart) begin
                    lives_n = LIVES_RL;
                end else if (ground_hit) begin
                    state_n = DEAD;
                    lives_n = '0;
                    hit_n   = 1'b1;
                end else if (pipe_hit) begin
                    hit_n = 1'b1;
                    if (lives > 4'd1) begin
                        state_n    = flappy_pkg::GRACE;
                        lives_n    = lives - 4'd1;
                        grace_load = 1'b1;
                    end else begin
                        state_n = DEAD;
                        lives_n = '0;
                    end
                end
            end
            flappy_pkg::GRACE: begin
                if (restart) begin
                    state_n = ALIVE;
                    lives_n = LIVES_RL;
                end else if (ground_hit) begin
                    state_n = DEAD;
                    lives_n = '0;
                    hit_n   = 1'b1;
                end else if (frame_start && grace_done) begin
                    state_n = ALIVE;
                end
            end
            DEAD: begin
                if (restart) begin
                    state_n = ALIVE;
                    lives_n = LIVES_RL;
                end
            end
            default: begin
                state_n = ALIVE;
                lives_n = LIVES_RL;
            end
        endcase
        grace_clear = (state_n != flappy_pkg::GRACE) && !grace_load;
    end

    grace_timer #(.GW(8)) u_grace (
        .clk         (clk),
        .reset       (reset),
        .load        (grace_load),
        .clear       (grace_clear),
        .load_val    (8'(GRACE)),
        .frame_start (frame_start),
        .done        (grace_done)
    );

    assign die  = (state == DEAD);
    assign LEDR = die;

endmodule

// File: tb/tb_collision_monitor.sv
// Directed scenarios plus random play against a lives/grace reference model.
module tb_collision_monitor;

    localparam int G = 2;

    logic       clk = 1'b0;
    logic       reset, frame_start, restart;
    logic [9:0] x;
    logic [7:0] gp, gb;
    logic [8:0] bird_y;
    logic       hit, die, LEDR;
    logic [3:0] lives;

    int checks = 0;
    int errors = 0;

    // reference model: mode 0 playing, 1 invulnerable, 2 dead
    int m_mode, m_lives, m_grace;
    bit m_hit;

    collision_monitor #(.GRACE(G)) dut (
        .clk(clk), .reset(reset), .x(x), .gp(gp), .gb(gb), .bird_y(bird_y),
        .frame_start(frame_start), .restart(restart),
        .hit(hit), .die(die), .lives(lives), .LEDR(LEDR)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit ph, gh;
        ph = (x >= 200) && (x <= 231) && (gp == 255) && (gb == 255);
        gh = frame_start && (int'(bird_y) + 24 >= 440);
        m_hit = 0;
        if (reset) begin
            m_mode = 0; m_lives = 3; m_grace = 0;
        end else if (m_mode == 2) begin
            if (restart) begin m_mode = 0; m_lives = 3; end
        end else if (restart) begin
            m_mode = 0; m_lives = 3;
        end else if (gh) begin
            m_mode = 2; m_lives = 0; m_hit = 1;
        end else if (m_mode == 0 && ph) begin
            m_hit = 1;
            m_lives = m_lives - 1;
            if (m_lives == 0) m_mode = 2;
            else begin m_mode = 1; m_grace = G; end
        end else if (m_mode == 1 && frame_start) begin
            m_grace = m_grace - 1;
            if (m_grace == 0) m_mode = 0;
        end
    endtask

    task automatic cyc(input string tag, input int cx, input int cgp, input int cgb,
                       input int by, input bit fs, input bit rs, input bit rst);
        @(negedge clk);
        x = 10'(cx); gp = 8'(cgp); gb = 8'(cgb); bird_y = 9'(by);
        frame_start = fs; restart = rs; reset = rst;
        @(posedge clk);
        model_step();
        #1;
        chk({tag, ".hit"},   int'(hit),   int'(m_hit));
        chk({tag, ".die"},   int'(die),   (m_mode == 2) ? 1 : 0);
        chk({tag, ".lives"}, int'(lives), m_lives);
        chk({tag, ".ledr"},  int'(LEDR),  (m_mode == 2) ? 1 : 0);
    endtask

    task automatic idle(input string tag);
        cyc(tag, 0, 0, 0, 100, 0, 0, 0);
    endtask

    task automatic frame(input string tag);
        cyc(tag, 0, 0, 0, 100, 1, 0, 0);
    endtask

    task automatic pipe(input string tag, input int px);
        cyc(tag, px, 255, 255, 100, 0, 0, 0);
    endtask

    initial begin
        m_mode = 0; m_lives = 3; m_grace = 0; m_hit = 0;
        reset = 1; restart = 0; frame_start = 0; x = 0; gp = 0; gb = 0; bird_y = 100;

        cyc("rst", 0, 0, 0, 100, 0, 0, 1);
        cyc("rst", 0, 0, 0, 100, 0, 0, 1);
        chk("rst.lives_const", int'(lives), 3);
        chk("rst.die_const", int'(die), 0);

        // A / B / E
        pipe("A", 215);
        chk("A.hit_const", int'(hit), 1);
        chk("A.lives_const", int'(lives), 2);
        idle("A.after");
        pipe("B.ignored", 215);
        pipe("B.ignored2", 220);
        chk("B.lives_const", int'(lives), 2);
        frame("B.f1");
        pipe("B.still_grace", 215);
        frame("B.f2");
        pipe("E.hit2", 215);
        chk("E.lives1_const", int'(lives), 1);
        frame("E.f1"); frame("E.f2");
        pipe("E.hit3", 215);
        chk("E.lives0_const", int'(lives), 0);
        chk("E.die_const", int'(die), 1);
        chk("E.ledr_const", int'(LEDR), 1);
        pipe("E.dead_hold", 215);
        cyc("E.restart", 0, 0, 0, 100, 0, 1, 0);
        chk("E.restart_lives_const", int'(lives), 3);

        // C / D boundaries
        pipe("C.x199", 199);
        pipe("C.x232", 232);
        chk("C.nohit_lives_const", int'(lives), 3);
        pipe("C.x200", 200);
        frame("C.f1"); frame("C.f2");
        pipe("C.x231", 231);
        chk("C.lives_const", int'(lives), 1);
        cyc("C.restart", 0, 0, 0, 100, 0, 1, 0);
        cyc("D.gb254", 210, 255, 254, 100, 0, 0, 0);
        cyc("D.gp254", 210, 254, 255, 100, 0, 0, 0);

        // F: ground during grace
        pipe("F.enter_grace", 215);
        cyc("F.ground", 0, 0, 0, 420, 1, 0, 0);
        chk("F.die_const", int'(die), 1);
        idle("F.after");
        cyc("F.restart", 0, 0, 0, 100, 0, 1, 0);
        pipe("F2.enter_grace", 215);
        cyc("F2.ground_rs", 0, 0, 0, 420, 1, 1, 0);
        chk("F2.lives_const", int'(lives), 3);
        cyc("F3.y415", 0, 0, 0, 415, 1, 0, 0);
        cyc("F3.y416_nofs", 0, 0, 0, 416, 0, 0, 0);
        cyc("F3.y416", 0, 0, 0, 416, 1, 0, 0);
        cyc("F3.restart", 0, 0, 0, 100, 0, 1, 0);
        cyc("F3.y511", 0, 0, 0, 511, 1, 0, 0);
        cyc("F3.restart2", 0, 0, 0, 100, 0, 1, 0);

        // reset mid-grace leaves no residual invulnerability
        pipe("R.grace", 215);
        cyc("R.reset", 215, 255, 255, 100, 0, 0, 1);
        pipe("R.hit_again", 215);
        chk("R.lives_const", int'(lives), 2);

        for (int i = 0; i < 3000; i++) begin
            int rx, rby;
            bit rfs, rrs, rrst;
            rx   = $urandom_range(240, 190);
            rby  = ($urandom_range(15, 0) == 0) ? $urandom_range(511, 410) : $urandom_range(300, 0);
            rfs  = ($urandom_range(5, 0) == 0);
            rrs  = ($urandom_range(60, 0) == 0);
            rrst = ($urandom_range(250, 0) == 0);
            cyc("rand", rx, ($urandom_range(3, 0) != 0) ? 255 : 254,
                ($urandom_range(3, 0) != 0) ? 255 : 254, rby, rfs, rrs, rrst);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/collision_monitor.md
COLLISION_MONITOR -- requirements
Module: collision_monitor

Interface
REQ-001 Parameter XW, default 10, pixel x width.
REQ-002 Parameter YW, default 9, pixel/bird y width.
REQ-003 Parameter CW, default 8, green-channel width.
REQ-004 Parameter BIRD_X0, default 200, left column of bird box.
REQ-005 Parameter BIRD_W, default 32, bird box width in pixels.
REQ-006 Parameter BIRD_H, default 24, bird box height in pixels.
REQ-007 Parameter GROUND_Y, default 440, first row of ground.
REQ-008 Parameter LIVES, default 3, lives per game, legal range 1..15.
REQ-009 Parameter GRACE, default 60, invulnerability length in frames, legal range 1..255.
REQ-010 Reset and clock are decided as follows: reset reset, synchronous, active-high; clock clk.
REQ-011 Port clk, input, 1, system clock.
REQ-012 Port reset, input, 1, synchronous active-high reset.
REQ-013 Port x, input, XW, current pixel column.
REQ-014 Port gp, input, CW, pipe-layer green value at x.
REQ-015 Port gb, input, CW, bird-layer green value at x.
REQ-016 Port bird_y, input, YW, top row of bird box.
REQ-017 Port frame_start, input, 1, one-cycle pulse at start of each frame.
REQ-018 Port restart, input, 1, level request to start a new game.
REQ-019 Port hit, output, 1, one-cycle pulse for each life lost.
REQ-020 Port die, output, 1, high while in DEAD.
REQ-021 Port lives, output, 4, remaining lives.
REQ-022 Port LEDR, output, 1, copy of die.

Function
REQ-023 The block SHALL implement the states ALIVE, GRACE and DEAD.
REQ-024 pipe_hit SHALL be true when BIRD_X0 <= x <= BIRD_X0+BIRD_W-1 and gp == gb == all-ones; both bounds are inclusive.
REQ-025 ground_hit SHALL be true only in a frame_start cycle where bird_y+BIRD_H >= GROUND_Y, with the sum computed at YW+1 bits so it cannot wrap.
REQ-026 ALIVE with pipe_hit and lives > 1: lives decrements by 1, grace counter loads GRACE, next state GRACE.
REQ-027 ALIVE with pipe_hit and lives == 1: lives goes to 0, next state DEAD.
REQ-028 ground_hit in ALIVE or GRACE: lives goes to 0, next state DEAD; ground_hit is fatal regardless of lives or grace.
REQ-029 In GRACE, pipe_hit SHALL be ignored.
REQ-030 In GRACE, the grace counter SHALL decrement on each frame_start; a frame_start with counter == 1 returns the state to ALIVE.
REQ-031 DEAD SHALL hold until restart or reset; either one moves to ALIVE with lives = LIVES.
REQ-032 restart in ALIVE or GRACE SHALL also reload lives = LIVES and enter ALIVE.
REQ-033 Priority SHALL be reset > restart > ground_hit > pipe_hit.
REQ-034 hit SHALL pulse for exactly the one cycle after the edge at which any life-losing transition (REQ-026, REQ-027, REQ-028) is taken, and never otherwise.
REQ-035 Latency: an input condition sampled at edge N SHALL be visible on die and lives after edge N.
REQ-036 All outputs SHALL be registered or decoded directly from registered state.

Reset
REQ-037 On reset: state ALIVE, lives = LIVES, grace counter = 0, hit = 0, die = 0, LEDR = 0.
REQ-038 Reset mid-GRACE or mid-DEAD SHALL take effect at the next edge with no residual grace time.

Structure
REQ-039 Package flappy_pkg SHALL hold the state enum (ALIVE, GRACE, DEAD) and the constant GREEN_MAX = all-ones.
REQ-040 Sub-module grace_timer SHALL implement the loadable frame-decrement counter: load, frame_start, done.

Verification
REQ-041 Scenario A: reset, then x=215 with gp=gb=255 for 1 cycle -> hit pulses 1 cycle, lives 3->2, state GRACE.
REQ-042 Scenario B: in GRACE with GRACE=2, repeated pipe_hit -> lives stays 2; after 2 frame_start pulses -> state ALIVE.
REQ-043 Scenario C: boundary x=199 and x=232 with gp=gb=255 -> no hit; x=200 and x=231 -> hit.
REQ-044 Scenario D: gp=255, gb=254 at x=210 -> no hit.
REQ-045 Scenario E: three spaced pipe hits -> lives 3,2,1,0, die=1, LEDR=1; then restart -> lives 3, die=0.
REQ-046 Scenario F: bird_y=420 (420+24 >= 440) at frame_start during GRACE, restart low -> die=1, lives 0, one hit pulse; same stimulus with restart=1 -> stays ALIVE, lives 3.
